// File: rtl/one_hot_phase_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : one_hot_phase_seq_if
//  Description : Control/status bundle for the one-hot phase sequencer.
//                The master side issues start/stop/hold/force commands and
//                reads the phase select; the slave side is the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface one_hot_phase_seq_if #(
    parameter int N_PHASES  = 4,
    parameter int CNT_WIDTH = 8
);
    localparam int IDX_W = $clog2(N_PHASES);

    logic                 start;
    logic                 stop;
    logic                 hold;
    logic [CNT_WIDTH-1:0] dwell_in;
    logic                 force_valid;
    logic [N_PHASES-1:0]  force_sel;
    logic [N_PHASES-1:0]  sel;
    logic [IDX_W-1:0]     phase_idx;
    logic                 phase_done;
    logic                 force_ack;
    logic                 force_err;
    logic                 busy;

    modport master (
        output start, stop, hold, dwell_in, force_valid, force_sel,
        input  sel, phase_idx, phase_done, force_ack, force_err, busy
    );

    modport slave (
        input  start, stop, hold, dwell_in, force_valid, force_sel,
        output sel, phase_idx, phase_done, force_ack, force_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/one_hot_phase_seq.sv
`default_nettype none
// ============================================================================
//  Module      : one_hot_phase_seq
//  Description : Timed one-hot phase sequencer. Rotates a single active bit
//                through N_PHASES phases, each held for max(dwell_in,1)
//                cycles, with hold, stop and a handshaked forced jump.
//                All outputs come straight from flops so sel can drive mux
//                selects glitch-free.
//  Revision    : 1.0 - initial release
// ============================================================================
module one_hot_phase_seq #(
    parameter int N_PHASES  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    one_hot_phase_seq_if.slave  bus
);
    localparam int                   IDX_W       = $clog2(N_PHASES);
    localparam logic [N_PHASES-1:0]  c_SEL_FIRST = {{(N_PHASES-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Encoding puts RUN at 1 so busy is the state flop itself.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [N_PHASES-1:0]  r_sel;
    logic [IDX_W-1:0]     r_phase_idx;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_phase_done;
    logic                 r_force_ack;
    logic                 r_force_err;

    state_t               w_state_nxt;
    logic [N_PHASES-1:0]  w_sel_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic                 w_done_nxt;
    logic                 w_ack_nxt;
    logic                 w_err_nxt;
    logic [CNT_WIDTH-1:0] w_reload;
    logic                 w_force_onehot;

    // A dwell of 0 behaves like 1: the counter reload is dwell-1, floored at 0.
    assign w_reload = (bus.dwell_in == '0) ? '0 : (bus.dwell_in - c_CNT_ONE);

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    assign w_force_onehot = (bus.force_sel != '0) &&
                            ((bus.force_sel & (bus.force_sel - c_SEL_FIRST)) == '0);

    // State register and all registered outputs; async active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_phase_idx  <= '0;
            r_cnt        <= '0;
            r_phase_done <= 1'b0;
            r_force_ack  <= 1'b0;
            r_force_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_phase_idx  <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_phase_done <= w_done_nxt;
            r_force_ack  <= w_ack_nxt;
            r_force_err  <= w_err_nxt;
        end
    end

    // Next state with priority stop > force > start > hold > count/advance.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;

        if (bus.stop) begin
            w_state_nxt = ST_IDLE;
            w_sel_nxt   = '0;
            w_cnt_nxt   = '0;
        end else if (bus.force_valid) begin
            // A rejected force freezes everything for this cycle.
            if (w_force_onehot) begin
                w_state_nxt = ST_RUN;
                w_sel_nxt   = bus.force_sel;
                w_cnt_nxt   = w_reload;
                w_ack_nxt   = 1'b1;
            end else begin
                w_err_nxt   = 1'b1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = ST_RUN;
                        w_sel_nxt   = c_SEL_FIRST;
                        w_cnt_nxt   = w_reload;
                    end
                end
                ST_RUN: begin
                    if (!bus.hold) begin
                        if (r_cnt != '0) begin
                            w_cnt_nxt = r_cnt - c_CNT_ONE;
                        end else begin
                            w_sel_nxt  = {r_sel[N_PHASES-2:0], r_sel[N_PHASES-1]};
                            w_cnt_nxt  = w_reload;
                            w_done_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Binary encode of the next select so phase_idx is registered alongside sel.
    always_comb begin
        w_idx_nxt = '0;
        for (int i = 0; i < N_PHASES; i++) begin
            if (w_sel_nxt[i]) begin
                w_idx_nxt = w_idx_nxt | IDX_W'(i);
            end
        end
    end

    assign bus.sel        = r_sel;
    assign bus.phase_idx  = r_phase_idx;
    assign bus.phase_done = r_phase_done;
    assign bus.force_ack  = r_force_ack;
    assign bus.force_err  = r_force_err;
    assign bus.busy       = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_one_hot_phase_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_one_hot_phase_seq
//  Description : Directed self-checking bench for one_hot_phase_seq
//                (N_PHASES=4, CNT_WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_one_hot_phase_seq;
    localparam int N_PHASES  = 4;
    localparam int CNT_WIDTH = 8;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    one_hot_phase_seq_if #(.N_PHASES(N_PHASES), .CNT_WIDTH(CNT_WIDTH)) bus ();

    one_hot_phase_seq #(
        .N_PHASES  (N_PHASES),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the whole visible status against expected sel/done/busy.
    task automatic check_outs(input string tag, input logic [3:0] esel, input logic edone, input logic ebusy);
        logic [1:0] eidx;
        eidx = 2'd0;
        for (int i = 0; i < 4; i++) if (esel[i]) eidx = 2'(i);
        check_vec({tag, "_sel"},  32'(bus.sel),        32'(esel));
        check_vec({tag, "_idx"},  32'(bus.phase_idx),  32'(eidx));
        check_vec({tag, "_done"}, 32'(bus.phase_done), 32'(edone));
        check_vec({tag, "_busy"}, 32'(bus.busy),       32'(ebusy));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] dwell);
        bus.dwell_in = dwell;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.hold        = 1'b0;
        bus.dwell_in    = 8'd0;
        bus.force_valid = 1'b0;
        bus.force_sel   = 4'b0000;

        // Reset state
        tick(); tick();
        check_outs("rst", 4'b0000, 1'b0, 1'b0);
        check_vec("rst_ack", 32'(bus.force_ack), 32'd0);
        check_vec("rst_err", 32'(bus.force_err), 32'd0);
        rst_n = 1'b1;
        tick();
        check_outs("rst_idle", 4'b0000, 1'b0, 1'b0);

        // Normal rotation, dwell 3: each phase seen for 3 cycles
        do_start(8'd3);
        for (int k = 0; k < 13; k++) begin
            if (k > 0) tick();
            check_outs($sformatf("rot_k%0d", k), 4'(1 << ((k / 3) % 4)),
                       (k > 0) && (k % 3 == 0), 1'b1);
        end
        do_stop();
        check_outs("rot_stop", 4'b0000, 1'b0, 1'b0);

        // Dwell 0 acts as 1: advance every cycle, done continuously high
        do_start(8'd0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            check_outs($sformatf("d0_k%0d", k), 4'(1 << (k % 4)), k > 0, 1'b1);
        end
        do_stop();

        // Hold for 5 cycles mid-phase with dwell 4: phase 0 lasts 9, phase 1 lasts 4
        do_start(8'd4);
        check_outs("hold_k0", 4'b0001, 1'b0, 1'b1);
        for (int k = 1; k < 15; k++) begin
            logic [3:0] esel;
            bus.hold = (k >= 2 && k <= 6);
            tick();
            esel = (k < 9) ? 4'b0001 : (k < 13) ? 4'b0010 : 4'b0100;
            check_outs($sformatf("hold_k%0d", k), esel, (k == 9) || (k == 13), 1'b1);
        end
        bus.hold = 1'b0;
        do_stop();

        // Accepted force in the counter-zero cycle beats the natural advance
        do_start(8'd3);
        tick(); tick();                       // counter now 0, sel 0001
        bus.force_valid = 1'b1;
        bus.force_sel   = 4'b0100;
        tick();
        bus.force_valid = 1'b0;
        check_outs("facc", 4'b0100, 1'b0, 1'b1);
        check_vec("facc_ack", 32'(bus.force_ack), 32'd1);
        check_vec("facc_err", 32'(bus.force_err), 32'd0);
        tick();
        check_vec("facc_ack_pulse", 32'(bus.force_ack), 32'd0);
        tick();
        check_outs("facc_k5", 4'b0100, 1'b0, 1'b1);
        tick();
        check_outs("facc_adv", 4'b1000, 1'b1, 1'b1);

        // Rejected force (two bits): error pulse, phase untouched
        bus.force_valid = 1'b1;
        bus.force_sel   = 4'b0110;
        tick();
        bus.force_valid = 1'b0;
        check_outs("frej", 4'b1000, 1'b0, 1'b1);
        check_vec("frej_err", 32'(bus.force_err), 32'd1);
        check_vec("frej_ack", 32'(bus.force_ack), 32'd0);
        tick();
        check_vec("frej_err_pulse", 32'(bus.force_err), 32'd0);

        // Force with zero bits is also rejected
        bus.force_valid = 1'b1;
        bus.force_sel   = 4'b0000;
        tick();
        bus.force_valid = 1'b0;
        check_vec("fzero_err", 32'(bus.force_err), 32'd1);
        check_vec("fzero_ack", 32'(bus.force_ack), 32'd0);

        // Stop beats a same-cycle valid force
        bus.stop        = 1'b1;
        bus.force_valid = 1'b1;
        bus.force_sel   = 4'b0010;
        tick();
        bus.stop        = 1'b0;
        bus.force_valid = 1'b0;
        check_outs("sf", 4'b0000, 1'b0, 1'b0);
        check_vec("sf_ack", 32'(bus.force_ack), 32'd0);
        do_start(8'd2);
        check_outs("sf_restart", 4'b0001, 1'b0, 1'b1);

        // Force accepted from IDLE enters RUN
        do_stop();
        bus.force_valid = 1'b1;
        bus.force_sel   = 4'b1000;
        tick();
        bus.force_valid = 1'b0;
        check_outs("fidle", 4'b1000, 1'b0, 1'b1);
        check_vec("fidle_ack", 32'(bus.force_ack), 32'd1);
        do_stop();

        // Async reset between edges during the first cycle of phase 2
        do_start(8'd3);
        for (int k = 1; k <= 6; k++) tick();
        check_outs("ar_pre", 4'b0100, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("ar_now", 4'b0000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        tick(); tick(); tick();
        check_outs("ar_idle", 4'b0000, 1'b0, 1'b0);
        do_start(8'd3);
        check_outs("ar_restart", 4'b0001, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
